// File: rtl/debug_unit.sv
// Host-side debug controller for the MIPS pipeline: UART program load, run/step gating and state dump.
// Optional DEBUG_UNIT_CYCLE_COUNT_EN appends a saturating enabled-cycle counter as the last dump word.
//
// state  | meaning
// IDLE   | waiting for a command byte ('L', 'C', 'S')
// LOAD   | assembling MSB-first words and writing instruction memory
// RUN    | pipeline enabled until halt is sampled
// STEP   | pipeline enabled for a single cycle
// DUMP   | streaming PC, registers, data memory (and cycle count) to the host
module debug_unit #(
  parameter int LEN        = 32,
  parameter int NB_BYTE    = 8,
  parameter int IMEM_DEPTH = 256,
  parameter int MEM_WORDS  = 16,
  parameter int N_REGS     = 32,
  parameter int READ_LAT   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NB_BYTE-1:0] rx_data,
  input  logic               rx_done,
  input  logic               tx_done,
  output logic               tx_start,
  output logic [NB_BYTE-1:0] tx_data,
  input  logic               mips_halt,
  input  logic [LEN-1:0]     mips_pc,
  input  logic [LEN-1:0]     mips_reg_data,
  input  logic [LEN-1:0]     mips_mem_data,
  output logic               mips_enable,
  output logic               mips_reset,
  output logic               debug_flag,
  output logic [LEN-1:0]     addr_debug,
  output logic [LEN-1:0]     addr_mem_inst,
  output logic [LEN-1:0]     ins_to_mem,
  output logic               wea_ram_inst
);

  localparam int BPW = LEN / NB_BYTE;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WCW = $clog2(1 + N_REGS + MEM_WORDS + 1);
  localparam int LW  = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
  localparam int N_WORDS = 2 + N_REGS + MEM_WORDS;
`else
  localparam int N_WORDS = 1 + N_REGS + MEM_WORDS;
`endif
  localparam logic [WCW-1:0] REG_LAST  = WCW'(N_REGS);
  localparam logic [WCW-1:0] MEM_LAST  = WCW'(N_REGS + MEM_WORDS);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(N_WORDS - 1);
  localparam logic [BCW-1:0] BYTE_LAST = BCW'(BPW - 1);
  localparam logic [LEN-1:0] IMEM_LAST = LEN'(IMEM_DEPTH - 1);
  localparam logic [NB_BYTE-1:0] CMD_L = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] CMD_C = NB_BYTE'(8'h43);
  localparam logic [NB_BYTE-1:0] CMD_S = NB_BYTE'(8'h53);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_STEP, S_DUMP} state_t;
  typedef enum logic [1:0] {D_ADDR, D_WAIT, D_SEND, D_TXW} dphase_t;

  state_t             state_q, state_d;
  dphase_t            dph_q, dph_d;
  logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [WCW-1:0]     word_cnt_q, word_cnt_d;
  logic [LW-1:0]      lat_q, lat_d;
  logic [LEN-1:0]     shift_q, shift_d;
  logic               tx_start_q, tx_start_d;
  logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
  logic               mips_enable_q, mips_enable_d;
  logic               mips_reset_q, mips_reset_d;
  logic               debug_flag_q, debug_flag_d;
  logic [LEN-1:0]     addr_debug_q, addr_debug_d;
  logic [LEN-1:0]     addr_mem_inst_q, addr_mem_inst_d;
  logic [LEN-1:0]     ins_to_mem_q, ins_to_mem_d;
  logic               wea_q, wea_d;

  logic               load_cmd;
  logic [LEN-1:0]     load_word;
  logic [LEN-1:0]     dump_addr;
  logic [LEN-1:0]     cap_word;

  assign load_cmd  = (state_q == S_IDLE) && rx_done && (rx_data == CMD_L);
  assign load_word = {shift_q[LEN-NB_BYTE-1:0], rx_data};

`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (load_cmd)
      cyc_cnt_d = '0;
    else if (mips_enable_q && (cyc_cnt_q != '1))
      cyc_cnt_d = cyc_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cyc_cnt_q <= '0;
    else        cyc_cnt_q <= cyc_cnt_d;
  end
`endif

  // word index 0 is the PC, then registers, then data memory words (byte addressed)
  always_comb begin
    if (word_cnt_q == '0)
      dump_addr = '0;
    else if (word_cnt_q <= REG_LAST)
      dump_addr = LEN'(word_cnt_q) - LEN'(1);
    else
      dump_addr = (LEN'(word_cnt_q) - LEN'(N_REGS + 1)) << 2;
  end

  always_comb begin
    if (word_cnt_q == '0)
      cap_word = mips_pc;
    else if (word_cnt_q <= REG_LAST)
      cap_word = mips_reg_data;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    else if (word_cnt_q <= MEM_LAST)
      cap_word = mips_mem_data;
    else
      cap_word = LEN'(cyc_cnt_q);
`else
    else
      cap_word = mips_mem_data;
`endif
  end

  always_comb begin
    state_d         = state_q;
    dph_d           = dph_q;
    byte_cnt_d      = byte_cnt_q;
    word_cnt_d      = word_cnt_q;
    lat_d           = lat_q;
    shift_d         = shift_q;
    tx_start_d      = 1'b0;
    tx_data_d       = tx_data_q;
    mips_enable_d   = 1'b0;
    mips_reset_d    = 1'b0;
    debug_flag_d    = debug_flag_q;
    addr_debug_d    = addr_debug_q;
    addr_mem_inst_d = addr_mem_inst_q;
    ins_to_mem_d    = ins_to_mem_q;
    wea_d           = 1'b0;
    case (state_q)
      S_IDLE: begin
        debug_flag_d = 1'b0;
        if (load_cmd) begin
          state_d         = S_LOAD;
          byte_cnt_d      = '0;
          addr_mem_inst_d = '0;
        end else if (rx_done && (rx_data == CMD_C)) begin
          state_d = S_RUN;
        end else if (rx_done && (rx_data == CMD_S)) begin
          state_d = S_STEP;
        end
      end
      S_LOAD: begin
        if (rx_done) begin
          shift_d = load_word;
          if (byte_cnt_q == BYTE_LAST) begin
            byte_cnt_d   = '0;
            ins_to_mem_d = load_word;
            wea_d        = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
        // the write cycle decides whether loading ends; the address moves on regardless
        if (wea_q) begin
          addr_mem_inst_d = addr_mem_inst_q + LEN'(1);
          if (ins_to_mem_q == '1) begin
            mips_reset_d = 1'b1;
            state_d      = S_IDLE;
          end else if (addr_mem_inst_q == IMEM_LAST) begin
            state_d = S_IDLE;
          end
        end
      end
      S_RUN, S_STEP: begin
        if (mips_halt || ((state_q == S_STEP) && mips_enable_q)) begin
          state_d      = S_DUMP;
          dph_d        = D_ADDR;
          word_cnt_d   = '0;
          debug_flag_d = 1'b1;
        end else begin
          mips_enable_d = 1'b1;
        end
      end
      S_DUMP: begin
        case (dph_q)
          D_ADDR: begin
            addr_debug_d = dump_addr;
            lat_d        = LW'(READ_LAT);
            dph_d        = D_WAIT;
          end
          D_WAIT: begin
            if (lat_q == '0) begin
              shift_d    = cap_word;
              byte_cnt_d = '0;
              dph_d      = D_SEND;
            end else begin
              lat_d = lat_q - LW'(1);
            end
          end
          D_SEND: begin
            tx_start_d = 1'b1;
            tx_data_d  = shift_q[LEN-1 -: NB_BYTE];
            dph_d      = D_TXW;
          end
          default: begin
            if (tx_done) begin
              shift_d = shift_q << NB_BYTE;
              if (byte_cnt_q != BYTE_LAST) begin
                byte_cnt_d = byte_cnt_q + BCW'(1);
                dph_d      = D_SEND;
              end else if (word_cnt_q == WORD_LAST) begin
                state_d      = S_IDLE;
                debug_flag_d = 1'b0;
                addr_debug_d = '0;
              end else begin
                word_cnt_d = word_cnt_q + WCW'(1);
                dph_d      = D_ADDR;
              end
            end
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      dph_q           <= D_ADDR;
      byte_cnt_q      <= '0;
      word_cnt_q      <= '0;
      lat_q           <= '0;
      shift_q         <= '0;
      tx_start_q      <= 1'b0;
      tx_data_q       <= '0;
      mips_enable_q   <= 1'b0;
      mips_reset_q    <= 1'b1;
      debug_flag_q    <= 1'b0;
      addr_debug_q    <= '0;
      addr_mem_inst_q <= '0;
      ins_to_mem_q    <= '0;
      wea_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      dph_q           <= dph_d;
      byte_cnt_q      <= byte_cnt_d;
      word_cnt_q      <= word_cnt_d;
      lat_q           <= lat_d;
      shift_q         <= shift_d;
      tx_start_q      <= tx_start_d;
      tx_data_q       <= tx_data_d;
      mips_enable_q   <= mips_enable_d;
      mips_reset_q    <= mips_reset_d;
      debug_flag_q    <= debug_flag_d;
      addr_debug_q    <= addr_debug_d;
      addr_mem_inst_q <= addr_mem_inst_d;
      ins_to_mem_q    <= ins_to_mem_d;
      wea_q           <= wea_d;
    end
  end

  assign tx_start      = tx_start_q;
  assign tx_data       = tx_data_q;
  assign mips_enable   = mips_enable_q;
  assign mips_reset    = mips_reset_q;
  assign debug_flag    = debug_flag_q;
  assign addr_debug    = addr_debug_q;
  assign addr_mem_inst = addr_mem_inst_q;
  assign ins_to_mem    = ins_to_mem_q;
  assign wea_ram_inst  = wea_q;

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: stimulus pushes expected tx bytes / imem writes, a monitor pops them.
module tb_debug_unit;

`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
  localparam int N_DUMP = 200;
`else
  localparam int N_DUMP = 196;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        tx_done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        mips_halt;
  logic [31:0] mips_pc;
  logic [31:0] mips_reg_data;
  logic [31:0] mips_mem_data;
  logic        mips_enable;
  logic        mips_reset;
  logic        debug_flag;
  logic [31:0] addr_debug;
  logic [31:0] addr_mem_inst;
  logic [31:0] ins_to_mem;
  logic        wea_ram_inst;

  always #5 clk = ~clk;

  debug_unit dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
    .tx_start(tx_start), .tx_data(tx_data), .mips_halt(mips_halt), .mips_pc(mips_pc),
    .mips_reg_data(mips_reg_data), .mips_mem_data(mips_mem_data), .mips_enable(mips_enable),
    .mips_reset(mips_reset), .debug_flag(debug_flag), .addr_debug(addr_debug),
    .addr_mem_inst(addr_mem_inst), .ins_to_mem(ins_to_mem), .wea_ram_inst(wea_ram_inst)
  );

  typedef struct {
    logic [7:0]  b;
    bit          chk_addr;
    logic [31:0] addr;
  } tx_exp_t;

  tx_exp_t     exp_tx[$];
  logic [63:0] exp_wr[$];

  int n_pass = 0;
  int n_total = 0;
  int tx_cnt = 0;
  int rst_pulses = 0;
  int en_cnt = 0;
  int halt_after = 1000;
  bit halt_force = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  // registered read model of the pipeline: reg[i] = 3*i, mem[a] = 0x10000000 + 7*a
  initial begin
    mips_reg_data = '0;
    mips_mem_data = '0;
    forever begin
      @(posedge clk);
      #1;
      mips_reg_data = addr_debug * 32'd3;
      mips_mem_data = 32'h1000_0000 + addr_debug * 32'd7;
    end
  end

  initial begin
    mips_halt = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && mips_enable) en_cnt++;
      mips_halt = halt_force || (en_cnt >= halt_after);
    end
  end

  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && tx_start) begin
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  initial begin
    tx_exp_t e;
    logic [63:0] w;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (tx_start) begin
          tx_cnt++;
          if (exp_tx.size() == 0) begin
            check("tx_unexpected_byte", {56'd0, tx_data}, 64'hFFFF);
          end else begin
            e = exp_tx.pop_front();
            check("tx_byte", {56'd0, tx_data}, {56'd0, e.b});
            check("tx_debug_flag", {63'd0, debug_flag}, 64'd1);
            if (e.chk_addr) check("addr_debug", {32'd0, addr_debug}, {32'd0, e.addr});
          end
        end
        if (wea_ram_inst) begin
          if (exp_wr.size() == 0) begin
            check("wr_unexpected", {addr_mem_inst, ins_to_mem}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            w = exp_wr.pop_front();
            check("wr_addr_data", {addr_mem_inst, ins_to_mem}, w);
          end
        end
        if (mips_reset) rst_pulses++;
      end
    end
  end

  task automatic push_word(input logic [31:0] wd, input bit ca, input logic [31:0] a);
    tx_exp_t e;
    for (int k = 3; k >= 0; k--) begin
      e.b = wd[8*k +: 8];
      e.chk_addr = ca;
      e.addr = a;
      exp_tx.push_back(e);
    end
  endtask

  task automatic push_dump(input logic [31:0] pc, input logic [31:0] cyc);
    push_word(pc, 1'b0, 32'd0);
    for (int i = 0; i < 32; i++) push_word(i * 3, 1'b1, i);
    for (int i = 0; i < 16; i++) push_word(32'h1000_0000 + 4 * i * 7, 1'b1, 4 * i);
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    push_word(cyc, 1'b0, 32'd0);
`else
    if (cyc == 32'hFFFF_FFFF) push_word(cyc, 1'b0, 32'd0);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] wd);
    for (int k = 3; k >= 0; k--) send_byte(wd[8*k +: 8]);
  endtask

  task automatic wait_dump(input string nm);
    bit done = 1'b0;
    for (int k = 0; k < 8000 && !done; k++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && !debug_flag) done = 1'b1;
    end
    check(nm, {63'd0, done}, 64'd1);
    repeat (20) @(negedge clk);
    check({nm, "_queue_empty"}, exp_tx.size(), 64'd0);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_mips_reset"}, {63'd0, mips_reset}, 64'd1);
    check({nm, "_tx_start"}, {63'd0, tx_start}, 64'd0);
    check({nm, "_tx_data"}, {56'd0, tx_data}, 64'd0);
    check({nm, "_enable"}, {63'd0, mips_enable}, 64'd0);
    check({nm, "_debug_flag"}, {63'd0, debug_flag}, 64'd0);
    check({nm, "_addr_debug"}, {32'd0, addr_debug}, 64'd0);
    check({nm, "_imem_addr"}, {32'd0, addr_mem_inst}, 64'd0);
    check({nm, "_ins_to_mem"}, {32'd0, ins_to_mem}, 64'd0);
    check({nm, "_wea"}, {63'd0, wea_ram_inst}, 64'd0);
  endtask

  initial begin
    int base;
    bit seen;
    reset = 1'b0;
    rx_data = '0;
    rx_done = 1'b0;
    mips_pc = 32'h0040_0010;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_mips_reset", {63'd0, mips_reset}, 64'd0);

    // unknown byte in IDLE does nothing
    send_byte(8'h58);
    repeat (6) @(negedge clk);
    check("x_debug_flag", {63'd0, debug_flag}, 64'd0);
    check("x_enable", {63'd0, mips_enable}, 64'd0);

    // full instruction memory without HALT: 256 writes, the 257th word is dropped
    rst_pulses = 0;
    send_byte(8'h4C);
    for (int i = 0; i < 256; i++) begin
      exp_wr.push_back({i[31:0], i[31:0] + 32'd1});
      send_word(i + 1);
    end
    send_word(32'h0000_0000);
    repeat (6) @(negedge clk);
    check("full_wr_queue_empty", exp_wr.size(), 64'd0);
    check("full_no_mips_reset", rst_pulses, 64'd0);

    // program with HALT
    rst_pulses = 0;
    exp_wr.push_back({32'd0, 32'h0000_0021});
    exp_wr.push_back({32'd1, 32'hFFFF_FFFF});
    send_byte(8'h4C);
    send_word(32'h0000_0021);
    send_word(32'hFFFF_FFFF);
    repeat (6) @(negedge clk);
    check("load_wr_queue_empty", exp_wr.size(), 64'd0);
    check("load_mips_reset_pulses", rst_pulses, 64'd1);
    check("load_idle_flag", {63'd0, debug_flag}, 64'd0);

    // continuous run, halt after 10 enabled cycles; command bytes during dump are ignored
    en_cnt = 0; halt_after = 10; halt_force = 1'b0;
    mips_pc = 32'h0000_0028;
    push_dump(mips_pc, 32'd10);
    send_byte(8'h43);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (debug_flag) seen = 1'b1;
    end
    check("run_enters_dump", {63'd0, seen}, 64'd1);
    send_byte(8'h53);
    send_byte(8'h4C);
    send_byte(8'h43);
    wait_dump("run_dump");
    check("run_enable_cycles", en_cnt, 64'd10);

    // single step with halt low
    en_cnt = 0; halt_after = 1000;
    mips_pc = 32'hA5C3_0104;
    base = tx_cnt;
    push_dump(mips_pc, 32'd11);
    send_byte(8'h53);
    wait_dump("step_dump");
    check("step_enable_cycles", en_cnt, 64'd1);
    check("step_byte_count", tx_cnt - base, N_DUMP);

    // step and run with halt already high: no enabled cycle
    en_cnt = 0; halt_force = 1'b1;
    push_dump(mips_pc, 32'd11);
    send_byte(8'h53);
    wait_dump("step_halted_dump");
    check("step_halted_enable", en_cnt, 64'd0);
    push_dump(mips_pc, 32'd11);
    send_byte(8'h43);
    wait_dump("run_halted_dump");
    check("run_halted_enable", en_cnt, 64'd0);

    // reset in the middle of a dump
    halt_force = 1'b0; en_cnt = 0;
    base = tx_cnt;
    push_dump(mips_pc, 32'd11);
    send_byte(8'h53);
    seen = 1'b0;
    for (int k = 0; k < 4000 && !seen; k++) begin
      @(negedge clk);
      if (tx_cnt - base >= 50) seen = 1'b1;
    end
    check("abort_reached_50", {63'd0, seen}, 64'd1);
    reset = 1'b0;
    exp_tx.delete();
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b1;
    base = tx_cnt;
    repeat (40) @(negedge clk);
    check("abort_no_tx", tx_cnt - base, 64'd0);

    en_cnt = 0;
    mips_pc = 32'h0000_1234;
    base = tx_cnt;
    push_dump(mips_pc, 32'd1);
    send_byte(8'h53);
    wait_dump("after_abort_dump");
    check("after_abort_bytes", tx_cnt - base, N_DUMP);
    check("final_wr_queue_empty", exp_wr.size(), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
